// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the dual-clock FIFO (w_clk domain).
// Owns the binary/Gray write pointers, brings the read-domain Gray pointer
// across with a two-flop synchronizer and derives full, almost-full, level
// and a sticky overflow flag for the producer.  The full flag is computed
// against the synchronized (delayed) read pointer, so it can only be late to
// clear, never early.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int AFULL_TH   = 1020
) (
    input  logic                  w_clk,
    input  logic                  rst_n,
    input  logic                  w_req,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  overflow
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_TH_L = AFULL_TH[AW:0];

    // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] r_wbin;
    logic [AW:0] r_wptr_gray;
    logic [AW:0] r_rq1;
    logic [AW:0] r_rq2;
    logic        r_wfull;
    logic        r_overflow;

    logic [AW:0] w_wbin_next;
    logic [AW:0] w_wgray_next;
    logic [AW:0] w_full_pattern;
    logic [AW:0] w_rq2_bin;
    logic        w_full_next;
    logic        w_ovf_evt;
    logic        w_wr;

    // Next-pointer, full-compare and level arithmetic.
    always_comb begin
        w_wr           = w_req & ~r_wfull;
        w_wbin_next    = r_wbin + {{AW{1'b0}}, w_wr};
        w_wgray_next   = w_wbin_next ^ (w_wbin_next >> 1);
        // Full when the write pointer is exactly one lap ahead: in Gray code
        // that means the two MSBs inverted and the rest equal.
        w_full_pattern = {~r_rq2[AW:AW-1], r_rq2[AW-2:0]};
        w_full_next    = (w_wgray_next == w_full_pattern);
        w_rq2_bin      = gray2bin(r_rq2);
        w_ovf_evt      = w_req & r_wfull;
    end

    // Write pointers in binary and Gray; Gray is registered so the read
    // domain only ever sees single-bit transitions.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin      <= '0;
            r_wptr_gray <= '0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wptr_gray <= w_wgray_next;
        end
    end

    // Two-flop synchronizer for the read pointer; nothing between the stages.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= rptr_gray;
            r_rq2 <= r_rq1;
        end
    end

    // Registered full flag, asserted on the edge that consumes the last slot.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wfull <= 1'b0;
        end else begin
            r_wfull <= w_full_next;
        end
    end

    // Sticky overflow; a new event wins over a simultaneous clear.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Output mapping; level wraps modulo 2**(AW+1) so it stays correct
    // across pointer lap boundaries.
    always_comb begin
        w_en         = w_wr;
        w_addr       = r_wbin[AW-1:0];
        wptr_gray    = r_wptr_gray;
        wfull        = r_wfull;
        w_level      = r_wbin - w_rq2_bin;
        walmost_full = (w_level >= AFULL_TH_L);
        overflow     = r_overflow;
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ADDR_WIDTH=3, AFULL_TH=6.
module tb_fifo_wr_ctrl;

    localparam int AW = 3;

    logic          w_clk;
    logic          rst_n;
    logic          w_req;
    logic          ovf_clr;
    logic [AW:0]   rptr_gray;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   w_level;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_TH(6)) dut (
        .w_clk        (w_clk),
        .rst_n        (rst_n),
        .w_req        (w_req),
        .ovf_clr      (ovf_clr),
        .rptr_gray    (rptr_gray),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .w_level      (w_level),
        .overflow     (overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       req;
        logic       clr;
        logic [3:0] rptr;
        logic       en;     // before the edge
        logic [2:0] addr;   // before the edge
        logic [3:0] gray;   // after the edge
        logic       full;
        logic [3:0] lvl;
        logic       af;
        logic       ovf;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic req, logic clr, logic [3:0] rptr, logic en,
                                logic [2:0] addr, logic [3:0] gray, logic full,
                                logic [3:0] lvl, logic af, logic ovf);
        vec_t v;
        v.req = req; v.clr = clr; v.rptr = rptr; v.en = en; v.addr = addr;
        v.gray = gray; v.full = full; v.lvl = lvl; v.af = af; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [3:0] g(input int x);
        logic [3:0] b;
        b = x[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        w_req = 1'b0; ovf_clr = 1'b0; rptr_gray = '0;
        rst_n = 1'b0;
        @(negedge w_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Main sequence: fill, overflow, clear, read-pointer release, refill.
        vecs[0]  = mk(1,0,0, 1,0,  1,0,1,0,0);
        vecs[1]  = mk(1,0,0, 1,1,  3,0,2,0,0);
        vecs[2]  = mk(1,0,0, 1,2,  2,0,3,0,0);
        vecs[3]  = mk(1,0,0, 1,3,  6,0,4,0,0);
        vecs[4]  = mk(1,0,0, 1,4,  7,0,5,0,0);
        vecs[5]  = mk(1,0,0, 1,5,  5,0,6,1,0);
        vecs[6]  = mk(1,0,0, 1,6,  4,0,7,1,0);
        vecs[7]  = mk(1,0,0, 1,7, 12,1,8,1,0);
        vecs[8]  = mk(1,0,0, 0,0, 12,1,8,1,1);
        vecs[9]  = mk(0,1,0, 0,0, 12,1,8,1,0);
        vecs[10] = mk(0,0,1, 0,0, 12,1,8,1,0);
        vecs[11] = mk(0,0,1, 0,0, 12,1,7,1,0);
        vecs[12] = mk(0,0,1, 0,0, 12,0,7,1,0);
        vecs[13] = mk(1,0,1, 1,0, 13,1,8,1,0);
        vecs[14] = mk(1,1,1, 0,1, 13,1,8,1,1);
        vecs[15] = mk(0,1,1, 0,1, 13,1,8,1,0);

        // Reset state, with w_req high to see w_en follow it.
        rst_n = 1'b0; w_req = 1'b1; ovf_clr = 1'b0; rptr_gray = '0;
        #2;
        check("rst_w_en",      w_en, 1);
        check("rst_w_addr",    w_addr, 0);
        check("rst_wptr_gray", wptr_gray, 0);
        check("rst_wfull",     wfull, 0);
        check("rst_w_level",   w_level, 0);
        check("rst_afull",     walmost_full, 0);
        check("rst_overflow",  overflow, 0);
        #5;
        check("rst_hold_gray", wptr_gray, 0);
        w_req = 1'b0;
        @(negedge w_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            w_req = vecs[i].req; ovf_clr = vecs[i].clr; rptr_gray = vecs[i].rptr;
            #1;
            check($sformatf("v%0d_w_en", i),   w_en,   vecs[i].en);
            check($sformatf("v%0d_w_addr", i), w_addr, vecs[i].addr);
            @(posedge w_clk); #1;
            check($sformatf("v%0d_gray", i),  wptr_gray,    vecs[i].gray);
            check($sformatf("v%0d_full", i),  wfull,        vecs[i].full);
            check($sformatf("v%0d_level", i), w_level,      vecs[i].lvl);
            check($sformatf("v%0d_afull", i), walmost_full, vecs[i].af);
            check($sformatf("v%0d_ovf", i),   overflow,     vecs[i].ovf);
            @(negedge w_clk);
        end

        // Wrap: read pointer trails the write pointer by two words.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            w_req = 1'b1;
            rptr_gray = g((k >= 2) ? k - 2 : 0);
            #1;
            check($sformatf("wrap%0d_w_en", k),   w_en, 1);
            check($sformatf("wrap%0d_w_addr", k), w_addr, k % 8);
            @(posedge w_clk); #1;
            check($sformatf("wrap%0d_gray", k), wptr_gray, g(k + 1));
            check($sformatf("wrap%0d_full", k), wfull, 0);
            check($sformatf("wrap%0d_ovf", k),  overflow, 0);
            if (k == 15) check("wrap_gray_zero_after_16", wptr_gray, 0);
            @(negedge w_clk);
        end
        w_req = 1'b0;

        // Reset mid-run after 5 writes, asserted and released between edges.
        do_reset();
        w_req = 1'b1;
        repeat (5) @(negedge w_clk);
        w_req = 1'b0;
        #1;
        check("mid_pre_level", w_level, 5);
        check("mid_pre_addr",  w_addr, 5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_gray",  wptr_gray, 0);
        check("mid_rst_addr",  w_addr, 0);
        check("mid_rst_level", w_level, 0);
        check("mid_rst_full",  wfull, 0);
        check("mid_rst_ovf",   overflow, 0);
        #1 rst_n = 1'b1;
        @(negedge w_clk);
        w_req = 1'b1;
        #1;
        check("mid_after_en",   w_en, 1);
        check("mid_after_addr", w_addr, 0);
        @(posedge w_clk); #1;
        check("mid_after_gray",  wptr_gray, 1);
        check("mid_after_level", w_level, 1);
        @(negedge w_clk);
        w_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the team's asynchronous FIFO, in the w_clk domain. It sits directly upstream of the dual-clock RAM and drives the RAM's write address and write enable. It keeps the binary and Gray write pointers and synchronizes the read-domain Gray pointer. It also produces the full, almost-full, level and overflow status for the producer.

Parameters:
ADDR_WIDTH, 10, RAM address width; FIFO depth = 2**ADDR_WIDTH
AFULL_TH, 1020, w_level threshold at or above which walmost_full asserts (1..2**ADDR_WIDTH)

Ports:
w_clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
w_req  input  1  producer write request; a word is accepted when w_req=1 and wfull=0
ovf_clr  input  1  synchronous clear of the sticky overflow flag
rptr_gray  input  ADDR_WIDTH+1  read pointer (Gray), asynchronous to w_clk
w_en  output  1  RAM write enable
w_addr  output  ADDR_WIDTH  RAM write address
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to the read domain
wfull  output  1  FIFO full
walmost_full  output  1  w_level >= AFULL_TH
w_level  output  ADDR_WIDTH+1  occupancy as seen from the write domain, 0..2**ADDR_WIDTH
overflow  output  1  sticky: set when w_req=1 while wfull=1

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is w_clk. When rst_n=0, all registers clear immediately:
  - wbin, wptr_gray, both synchronizer stages: 0
  - wfull, overflow: 0
  - Derived outputs then read w_addr=0, w_level=0, w_en=w_req, walmost_full=0.
- A reset mid-operation discards all pointer state. The RAM contents are not touched by this block.
- Write acceptance: w_en = w_req & ~wfull, combinational and in the same cycle as the request. w_addr = wbin[ADDR_WIDTH-1:0].
- Pointer update: on a w_clk edge with w_en=1, wbin <= wbin+1 (modulo 2**(ADDR_WIDTH+1)).
- Gray pointer: wptr_gray <= wbin_next ^ (wbin_next>>1), registered. wptr_gray changes by exactly one bit per write.
- Synchronizer: two flops, rq1 <= rptr_gray, rq2 <= rq1. No logic is placed between the two stages.
- Full flag: registered, wfull <= (gray(wbin_next) == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
  - wfull asserts on the same edge that accepts the last free slot.
  - wfull deasserts no earlier than 3 w_clk edges after rptr_gray changes (2 synchronizer edges + 1 flag edge).
  - wfull is therefore pessimistic and never optimistic.
- Level: w_level = wbin - gray2bin(rq2), computed in ADDR_WIDTH+1 bits, modulo wrap. walmost_full is combinational from w_level.
- Overflow:
  - Set on an edge where w_req=1 and wfull=1. No write occurs and the pointers are unchanged.
  - Cleared on an edge where ovf_clr=1 and no new overflow event occurs. A simultaneous set and clear leaves the flag set.
- Wrap-around: the address wraps from 2**ADDR_WIDTH-1 to 0. The extra MSB toggles, which distinguishes full from empty.
- Simultaneous write and read-pointer change: the full comparison uses the old rq2. Any resulting stale full clears on a later edge.
- Invariant: w_level never exceeds 2**ADDR_WIDTH, and no write is accepted while wfull=1.

Test Plan (ADDR_WIDTH=3, AFULL_TH=6):
- Reset, then w_req=1 for 8 cycles with rptr_gray=0 -> w_addr 0..7 with w_en=1; wptr_gray 1,3,2,6,7,5,4,12; wfull=1 after the 8th edge; w_level=8.
- Continuing from full, w_req=1 for 1 more cycle -> w_en=0, wptr_gray stays 12, overflow=1. Then ovf_clr=1 for 1 cycle -> overflow=0.
- Continuing from full, set rptr_gray=1 (read pointer 1) -> wfull falls on the 3rd w_clk edge after the change, with w_level=7 from the 2nd edge. The next w_req writes w_addr=0.
- From reset, 6 writes with rptr_gray=0 -> walmost_full=0 after 5 writes (w_level=5), =1 after the 6th.
- Wrap: 20 writes with rptr_gray tracking the write pointer delayed by 2 words -> w_addr sequence 0..7,0..7,0..3; wptr_gray is 0 after the 16th write; wfull never asserts; no overflow.
- Reset mid-run: after 5 writes, pulse rst_n low between edges -> immediately wptr_gray=0, w_addr=0, w_level=0, wfull=0, overflow=0. Writes after release restart at w_addr 0.
